// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// core load/store port (0) and the loader/debug port (1). Each access runs
// grant -> one memory command cycle -> optional read-wait, then back to IDLE.
module dmem_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [6:0]  addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [6:0]  addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        CEN,
  output logic        WEN,
  output logic        OEN,
  output logic [6:0]  A,
  output logic [31:0] Data2Mem,
  input  logic [31:0] ReadDataMem,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  logic [1:0]  r_state;
  logic        r_last;
  logic        r_we;
  logic        r_port;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_cnt;
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_access;

  // Grant decision: only in IDLE; on a tie port 0 wins under fixed priority,
  // otherwise the port that was not granted last time wins.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_access = (r_state == S_ACCESS);
    w_gnt0   = w_idle && req0 && (!req1 || FIXED_PRIO || r_last);
    w_gnt1   = w_idle && req1 && !w_gnt0;
  end

  // Command register and round-robin pointer, loaded in the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_port  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_last  <= w_gnt1;
      r_port  <= w_gnt1;
      r_we    <= w_gnt1 ? we1    : we0;
      r_addr  <= w_gnt1 ? addr1  : addr0;
      r_wdata <= w_gnt1 ? wdata1 : wdata0;
    end
  end

  // Access sequencer: IDLE -> ACCESS -> (write: IDLE | read: WAIT) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= LAT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read return: capture memory data on the last WAIT cycle and pulse the
  // owner's rvalid in the following (IDLE) cycle; the other port holds rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (r_state == S_WAIT && r_cnt == 3'd1) begin
        if (r_port) begin
          r_rdata1  <= ReadDataMem;
          r_rvalid1 <= 1'b1;
        end else begin
          r_rdata0  <= ReadDataMem;
          r_rvalid0 <= 1'b1;
        end
      end
    end
  end

  // Memory pins are decoded from registered state only, so reset idles them
  // immediately; the strobes are active solely in the ACCESS cycle.
  always_comb begin
    CEN      = !w_access;
    WEN      = !(w_access && r_we);
    OEN      = !(w_access && !r_we);
    A        = r_addr;
    Data2Mem = r_wdata;
    busy     = !w_idle;
    gnt0     = w_gnt0;
    gnt1     = w_gnt1;
    rvalid0  = r_rvalid0;
    rvalid1  = r_rvalid1;
    rdata0   = r_rdata0;
    rdata1   = r_rdata1;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: instance A (RD_LAT=1, round-robin) runs a
// cycle table; instance B (fixed priority) and instance C (RD_LAT=3) run
// hand-written sequences, C also covering reset in the middle of a read.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] OT = 32'h11111111;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  // ---------------- instance A: RD_LAT=1, round-robin ----------------
  logic        rst;
  logic        a_req0, a_we0, a_req1, a_we1;
  logic [6:0]  a_addr0, a_addr1;
  logic [31:0] a_wdata0, a_wdata1;
  logic        a_gnt0, a_gnt1, a_rv0, a_rv1;
  logic [31:0] a_rd0, a_rd1;
  logic        a_CEN, a_WEN, a_OEN, a_busy;
  logic [6:0]  a_A;
  logic [31:0] a_D, a_mrd;
  logic [7:0]  a_ctl;
  logic [31:0] mem_a [0:127];

  dmem_arbiter #(.RD_LAT(1), .FIXED_PRIO(1'b0)) u_a (
    .clk(clk), .rst(rst),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
    .CEN(a_CEN), .WEN(a_WEN), .OEN(a_OEN), .A(a_A), .Data2Mem(a_D),
    .ReadDataMem(a_mrd), .busy(a_busy)
  );

  assign a_ctl = {a_gnt0, a_gnt1, a_rv0, a_rv1, a_CEN, a_WEN, a_OEN, a_busy};

  always @(posedge clk) begin
    if (!a_CEN && !a_WEN) mem_a[a_A] <= a_D;
    if (!a_CEN && !a_OEN) a_mrd <= mem_a[a_A];
  end

  // ---------------- instance B: RD_LAT=1, fixed priority ----------------
  logic        b_req0, b_we0, b_req1, b_we1;
  logic [6:0]  b_addr0, b_addr1;
  logic [31:0] b_wdata0, b_wdata1;
  logic        b_gnt0, b_gnt1, b_rv0, b_rv1;
  logic [31:0] b_rd0, b_rd1;
  logic        b_CEN, b_WEN, b_OEN, b_busy;
  logic [6:0]  b_A;
  logic [31:0] b_D;
  logic [31:0] b_mrd = 32'h0;

  dmem_arbiter #(.RD_LAT(1), .FIXED_PRIO(1'b1)) u_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
    .CEN(b_CEN), .WEN(b_WEN), .OEN(b_OEN), .A(b_A), .Data2Mem(b_D),
    .ReadDataMem(b_mrd), .busy(b_busy)
  );

  // ---------------- instance C: RD_LAT=3, round-robin ----------------
  logic        rst_c;
  logic        c_req0, c_we0, c_req1, c_we1;
  logic [6:0]  c_addr0, c_addr1;
  logic [31:0] c_wdata0, c_wdata1;
  logic        c_gnt0, c_gnt1, c_rv0, c_rv1;
  logic [31:0] c_rd0, c_rd1;
  logic        c_CEN, c_WEN, c_OEN, c_busy;
  logic [6:0]  c_A;
  logic [31:0] c_D;
  logic [31:0] c_p1, c_p2, c_p3;
  logic [7:0]  c_ctl;
  logic [31:0] mem_c [0:127];

  dmem_arbiter #(.RD_LAT(3), .FIXED_PRIO(1'b0)) u_c (
    .clk(clk), .rst(rst_c),
    .req0(c_req0), .we0(c_we0), .addr0(c_addr0), .wdata0(c_wdata0),
    .gnt0(c_gnt0), .rvalid0(c_rv0), .rdata0(c_rd0),
    .req1(c_req1), .we1(c_we1), .addr1(c_addr1), .wdata1(c_wdata1),
    .gnt1(c_gnt1), .rvalid1(c_rv1), .rdata1(c_rd1),
    .CEN(c_CEN), .WEN(c_WEN), .OEN(c_OEN), .A(c_A), .Data2Mem(c_D),
    .ReadDataMem(c_p3), .busy(c_busy)
  );

  assign c_ctl = {c_gnt0, c_gnt1, c_rv0, c_rv1, c_CEN, c_WEN, c_OEN, c_busy};

  // Three-stage read pipeline: data valid RD_LAT=3 cycles after the command.
  always @(posedge clk) begin
    if (!c_CEN && !c_WEN) mem_c[c_A] <= c_D;
    if (!c_CEN && !c_OEN) c_p1 <= mem_c[c_A];
    c_p2 <= c_p1;
    c_p3 <= c_p2;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ctl bits: {gnt0, gnt1, rvalid0, rvalid1, CEN, WEN, OEN, busy}
  typedef struct {
    logic        req0;
    logic        we0;
    logic [6:0]  addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        we1;
    logic [6:0]  addr1;
    logic [31:0] wdata1;
    logic [7:0]  ctl;
    logic [6:0]  a;
    logic [31:0] d;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r0, input logic w0, input logic [6:0] ad0, input logic [31:0] wd0,
                     input logic r1, input logic w1, input logic [6:0] ad1, input logic [31:0] wd1,
                     input logic [7:0] ctl, input logic [6:0] a, input logic [31:0] d,
                     input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = ad0; v.wdata0 = wd0;
    v.req1 = r1; v.we1 = w1; v.addr1 = ad1; v.wdata1 = wd1;
    v.ctl = ctl; v.a = a; v.d = d; v.rd0 = rd0; v.rd1 = rd1;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; rst_c = 1'b1;
    a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    c_req0 = 0; c_we0 = 0; c_addr0 = '0; c_wdata0 = '0;
    c_req1 = 0; c_we1 = 0; c_addr1 = '0; c_wdata1 = '0;

    // Instance A cycle table (RD_LAT=1, round-robin).
    add(1,1,7'h05,DB, 0,0,7'h00,0,  8'b1000_1110, 7'h00, 0,  0,  0);  // write gnt0
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_0011, 7'h05, DB, 0,  0);  // write ACCESS
    add(1,0,7'h05,0,  0,0,7'h00,0,  8'b1000_1110, 7'h00, 0,  0,  0);  // read gnt0 (T)
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_0101, 7'h05, 0,  0,  0);  // read ACCESS
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_1111, 7'h00, 0,  0,  0);  // WAIT
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0010_1110, 7'h00, 0,  DB, 0);  // rvalid0 at T+3
    add(0,0,7'h00,0,  1,1,7'h10,OT, 8'b0100_1110, 7'h00, 0,  DB, 0);  // port1 write gnt
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_0011, 7'h10, OT, DB, 0);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b1000_1110, 7'h00, 0,  DB, 0);  // tie: port 0
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0000_0101, 7'h05, 0,  DB, 0);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0000_1111, 7'h00, 0,  DB, 0);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0110_1110, 7'h00, 0,  DB, 0);  // rvalid0 + gnt1
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0000_0101, 7'h10, 0,  DB, 0);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0000_1111, 7'h00, 0,  DB, 0);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b1001_1110, 7'h00, 0,  DB, OT); // rvalid1 + gnt0
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0000_0101, 7'h05, 0,  DB, OT);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0000_1111, 7'h00, 0,  DB, OT);
    add(1,0,7'h05,0,  1,0,7'h10,0,  8'b0110_1110, 7'h00, 0,  DB, OT); // rvalid0 + gnt1
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_0101, 7'h10, 0,  DB, OT);
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_1111, 7'h00, 0,  DB, OT);
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0001_1110, 7'h00, 0,  DB, OT); // rvalid1
    add(0,0,7'h00,0,  0,0,7'h00,0,  8'b0000_1110, 7'h00, 0,  DB, OT);

    // Reset held for 3 cycles, then reset-state checks.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {24'h0, a_ctl}, {24'h0, 8'b0000_1110});
    chk("reset_A",   {25'h0, a_A}, 32'h0);
    chk("reset_D",   a_D, 32'h0);
    chk("reset_rd0", a_rd0, 32'h0);
    chk("reset_rd1", a_rd1, 32'h0);
    @(negedge clk);
    rst = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle_ctl[%0d]", i), {24'h0, a_ctl}, {24'h0, 8'b0000_1110});
      @(negedge clk);
    end

    // Instance A table.
    for (int i = 0; i < vq.size(); i++) begin
      a_req0 = vq[i].req0; a_we0 = vq[i].we0; a_addr0 = vq[i].addr0; a_wdata0 = vq[i].wdata0;
      a_req1 = vq[i].req1; a_we1 = vq[i].we1; a_addr1 = vq[i].addr1; a_wdata1 = vq[i].wdata1;
      #1;
      chk($sformatf("row%0d_ctl", i), {24'h0, a_ctl}, {24'h0, vq[i].ctl});
      chk($sformatf("row%0d_rdata0", i), a_rd0, vq[i].rd0);
      chk($sformatf("row%0d_rdata1", i), a_rd1, vq[i].rd1);
      if (!vq[i].ctl[3]) chk($sformatf("row%0d_A", i), {25'h0, a_A}, {25'h0, vq[i].a});
      if (!vq[i].ctl[2]) chk($sformatf("row%0d_D", i), a_D, vq[i].d);
      @(negedge clk);
    end
    a_req0 = 0; a_req1 = 0;

    // Instance B: fixed priority, both held; port 1 starved until req0 drops.
    b_req0 = 1; b_addr0 = 7'h00; b_req1 = 1; b_addr1 = 7'h01;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("fp_gnt[%0d]", i), {30'h0, b_gnt0, b_gnt1},
          {30'h0, ((i % 3) == 0), 1'b0});
      @(negedge clk);
    end
    b_req0 = 0;
    #1;
    chk("fp_gnt1_after_drop", {30'h0, b_gnt0, b_gnt1}, {30'h0, 2'b01});
    @(negedge clk);
    b_req1 = 0;

    // Instance C: preload 7F, then port 1 read with RD_LAT=3.
    c_req1 = 1; c_we1 = 1; c_addr1 = 7'h7F; c_wdata1 = CF;
    #1;
    chk("lat_wr_gnt", {24'h0, c_ctl}, {24'h0, 8'b0100_1110});
    @(negedge clk);
    c_req1 = 0; c_we1 = 0; c_wdata1 = '0;
    @(negedge clk);
    c_req1 = 1; c_addr1 = 7'h7F;
    #1;
    chk("lat_rd_gnt", {24'h0, c_ctl}, {24'h0, 8'b0100_1110});
    @(negedge clk);
    c_req1 = 0;
    #1;
    chk("lat_access", {24'h0, c_ctl}, {24'h0, 8'b0000_0101});
    chk("lat_access_A", {25'h0, c_A}, {25'h0, 7'h7F});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("lat_wait[%0d]", i), {24'h0, c_ctl}, {24'h0, 8'b0000_1111});
    end
    @(negedge clk);
    #1;
    chk("lat_rvalid1", {24'h0, c_ctl}, {24'h0, 8'b0001_1110});
    chk("lat_rdata1", c_rd1, CF);

    // Instance C: port 0 read, reset asserted during WAIT.
    @(negedge clk);
    c_req0 = 1; c_we0 = 0; c_addr0 = 7'h7F;
    #1;
    chk("mid_gnt0", {24'h0, c_ctl}, {24'h0, 8'b1000_1110});
    @(negedge clk);
    c_req0 = 0;
    @(negedge clk);
    #1;
    chk("mid_wait", {24'h0, c_ctl}, {24'h0, 8'b0000_1111});
    #1 rst_c = 1'b1;
    #1;
    chk("mid_async_ctl", {24'h0, c_ctl}, {24'h0, 8'b0000_1110});
    chk("mid_async_A", {25'h0, c_A}, 32'h0);
    chk("mid_async_rd1", c_rd1, 32'h0);
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("mid_norv[%0d]", i), {24'h0, c_ctl}, {24'h0, 8'b0000_1110});
      chk($sformatf("mid_rd0[%0d]", i), c_rd0, 32'h0);
      @(negedge clk);
    end
    c_req0 = 1; c_we0 = 1; c_addr0 = 7'h01; c_wdata0 = 32'h1;
    c_req1 = 1; c_we1 = 1; c_addr1 = 7'h02; c_wdata1 = 32'h2;
    #1;
    chk("post_reset_tie", {24'h0, c_ctl}, {24'h0, 8'b1000_1110});
    @(negedge clk);
    c_req0 = 0; c_req1 = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
